// File: rtl/grid_access_arbiter_if.sv
// Requester and grid-RAM bundle for grid_access_arbiter.
// slave = arbiter side, master = walkers plus RAM model.
interface grid_access_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req;
  logic [2*NREQ-1:0]      op;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_ok;
  logic                   mem_re;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_din;
  logic [DATA_W-1:0]      mem_dout;

  modport slave (
    input  req, op, addr, wdata, mem_dout,
    output gnt, rsp_valid, rsp_data, rsp_ok,
    output mem_re, mem_we, mem_addr, mem_din
  );

  modport master (
    output req, op, addr, wdata, mem_dout,
    input  gnt, rsp_valid, rsp_data, rsp_ok,
    input  mem_re, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/grid_access_arbiter.sv
// Round-robin single-port grid RAM arbiter with read/write/atomic claim.
// Optional GRID_ARB_STATS_EN adds claim and claim-failure counters.
module grid_access_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 100,
  parameter logic [DATA_W-1:0] EMPTY = '1
) (
  input  logic clk,
  input  logic reset,
  grid_access_arbiter_if.slave bus
`ifdef GRID_ARB_STATS_EN
  ,
  output logic [31:0] stat_claims,
  output logic [31:0] stat_claim_fail
`endif
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_CL = 2'b10;
  localparam logic [1:0] OP_RS = 2'b11;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_RD, CLAIM_WR, RESP
  } state_t;

  state_t            state;
  logic [SW-1:0]     last;
  logic [SW-1:0]     sel;
  logic [1:0]        op_q;
  logic              bad_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic                   found;
  logic [SW-1:0]          pick;
  logic [NREQ-1:0]        req_rot;
  logic [2*NREQ-1:0]      op_sh;
  logic [NREQ*ADDR_W-1:0] addr_sh;
  logic [NREQ*DATA_W-1:0] wdata_sh;
  logic [1:0]             op_sel;
  logic [ADDR_W-1:0]      addr_sel;
  logic [DATA_W-1:0]      wdata_sel;
  logic                   bad_sel;

  function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] s);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << s;
  endfunction

  // search last+1, last+2, ... so the previous winner goes to the back
  always_comb begin
    found   = 1'b0;
    pick    = last;
    req_rot = '0;
    for (int i = 1; i <= NREQ; i++) begin
      req_rot = bus.req >> ((int'(last) + i) % NREQ);
      if (!found && req_rot[0]) begin
        found = 1'b1;
        pick  = SW'((int'(last) + i) % NREQ);
      end
    end
    op_sh     = bus.op >> (2 * int'(pick));
    addr_sh   = bus.addr >> (ADDR_W * int'(pick));
    wdata_sh  = bus.wdata >> (DATA_W * int'(pick));
    op_sel    = op_sh[1:0];
    addr_sel  = addr_sh[ADDR_W-1:0];
    wdata_sel = wdata_sh[DATA_W-1:0];
    bad_sel   = (op_sel == OP_RS) ||
                (addr_sel >= ADDR_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last          <= SW'(NREQ - 1);
      sel           <= '0;
      op_q          <= '0;
      bad_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_ok    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_din   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            last    <= pick;
            sel     <= pick;
            op_q    <= op_sel;
            bad_q   <= bad_sel;
            addr_q  <= addr_sel;
            wdata_q <= wdata_sel;
            bus.gnt <= onehot(pick);
            state   <= ISSUE;
            if (!bad_sel) begin
              bus.mem_addr <= addr_sel;
              if (op_sel == OP_WR) begin
                bus.mem_we  <= 1'b1;
                bus.mem_din <= wdata_sel;
              end else begin
                bus.mem_re  <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          bus.gnt      <= '0;
          bus.mem_re   <= 1'b0;
          bus.mem_we   <= 1'b0;
          bus.mem_addr <= '0;
          bus.mem_din  <= '0;
          if (bad_q) begin
            bus.rsp_valid <= onehot(sel);
            bus.rsp_data  <= EMPTY;
            bus.rsp_ok    <= 1'b0;
            state         <= RESP;
          end else if (op_q == OP_WR) begin
            bus.rsp_valid <= onehot(sel);
            bus.rsp_data  <= '0;
            bus.rsp_ok    <= 1'b1;
            state         <= RESP;
          end else begin
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // claim write follows the read directly, RAM stays locked
          if (op_q == OP_CL && bus.mem_dout == EMPTY) begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= addr_q;
            bus.mem_din  <= wdata_q;
            state        <= CLAIM_WR;
          end else begin
            bus.rsp_valid <= onehot(sel);
            bus.rsp_data  <= bus.mem_dout;
            bus.rsp_ok    <= (op_q == OP_RD);
            state         <= RESP;
          end
        end
        CLAIM_WR: begin
          bus.mem_we    <= 1'b0;
          bus.mem_addr  <= '0;
          bus.mem_din   <= '0;
          bus.rsp_valid <= onehot(sel);
          bus.rsp_data  <= EMPTY;
          bus.rsp_ok    <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          bus.rsp_valid <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRID_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_claims     <= '0;
      stat_claim_fail <= '0;
    end else if (state == RESP && op_q == OP_CL) begin
      stat_claims <= stat_claims + 32'd1;
      if (!bus.rsp_ok)
        stat_claim_fail <= stat_claim_fail + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed bench for grid_access_arbiter with a behavioural grid RAM.
// Build with GRID_ARB_STATS_EN to also check the claim counters.
module tb_grid_access_arbiter;
  localparam int NREQ = 4;
  localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  grid_access_arbiter_if #(.NREQ(NREQ), .ADDR_W(32), .DATA_W(32)) bus ();

`ifdef GRID_ARB_STATS_EN
  logic [31:0] stat_claims;
  logic [31:0] stat_claim_fail;
`endif

  grid_access_arbiter #(
    .NREQ(NREQ), .ADDR_W(32), .DATA_W(32), .DEPTH(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef GRID_ARB_STATS_EN
    ,
    .stat_claims(stat_claims),
    .stat_claim_fail(stat_claim_fail)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] ram [128];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[6:0]] <= bus.mem_din;
    if (bus.mem_re) bus.mem_dout <= ram[bus.mem_addr[6:0]];
  end

  int both_cnt = 0;
  int ovl_cnt = 0;
  int gmul_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_re && bus.mem_we) both_cnt++;
    if ($countones(bus.rsp_valid) > 1) ovl_cnt++;
    if ($countones(bus.gnt) > 1) gmul_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          g_cyc, lat;
  logic [3:0]  g_val, r_valid;
  logic [31:0] r_data, we_addr, we_din;
  logic        r_ok, saw_re, saw_we;

  task automatic run(input int idx, input logic [1:0] o,
                     input logic [31:0] a, input logic [31:0] d);
    bus.op[2*idx +: 2]  = o;
    bus.addr[32*idx +: 32]  = a;
    bus.wdata[32*idx +: 32] = d;
    bus.req[idx] = 1'b1;
    g_cyc = 0; lat = 0; g_val = '0; r_valid = '0;
    r_data = '0; r_ok = 1'b0; saw_re = 1'b0; saw_we = 1'b0;
    we_addr = '0; we_din = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.gnt != 0 && g_cyc == 0) begin
        g_cyc = c;
        g_val = bus.gnt;
      end
      if (bus.mem_re) saw_re = 1'b1;
      if (bus.mem_we) begin
        saw_we = 1'b1;
        we_addr = bus.mem_addr;
        we_din = bus.mem_din;
      end
      if (bus.rsp_valid != 0) begin
        lat = c;
        r_valid = bus.rsp_valid;
        r_data = bus.rsp_data;
        r_ok = bus.rsp_ok;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $error("FAIL timeout waiting rsp_valid req %0d", idx);
    end
    bus.req[idx] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] gseq [5];
    int n;
    for (int i = 0; i < 128; i++) ram[i] = EMPTY;
    bus.req = '0; bus.op = '0; bus.addr = '0; bus.wdata = '0;
    bus.mem_dout = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctl", {bus.gnt, bus.rsp_valid, bus.rsp_ok,
                    bus.mem_re, bus.mem_we}, 11'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_data", bus.rsp_data, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    bus.op[3:2] = 2'b10; bus.addr[63:32] = 32'd20;
    bus.wdata[63:32] = 32'd3; bus.req[1] = 1'b1;
    @(negedge clk);
    chk("abort_re", bus.mem_re, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out", {bus.gnt, bus.rsp_valid, bus.rsp_ok,
                      bus.mem_re, bus.mem_we}, 11'd0);
    chk("abort_data", bus.rsp_data, 32'd0);
    bus.req[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(2, 2'b00, 32'd20, 32'd0);
    chk("post_rst_gcyc", g_cyc, 1);
    chk("post_rst_gnt", g_val, 4'b0100);
    chk("post_rst_data", r_data, EMPTY);
    chk("post_rst_lat", lat, 3);

    run(1, 2'b10, 32'd5, 32'd7);
    chk("claim_ok_gnt", g_val, 4'b0010);
    chk("claim_ok_lat", lat, 4);
    chk("claim_ok_rv", r_valid, 4'b0010);
    chk("claim_ok_ok", r_ok, 1'b1);
    chk("claim_ok_data", r_data, EMPTY);
    chk("claim_ok_re", saw_re, 1'b1);
    chk("claim_ok_wa", we_addr, 32'd5);
    chk("claim_ok_wd", we_din, 32'd7);

    run(3, 2'b10, 32'd5, 32'd9);
    chk("claim_bad_lat", lat, 3);
    chk("claim_bad_ok", r_ok, 1'b0);
    chk("claim_bad_data", r_data, 32'd7);
    chk("claim_bad_we", saw_we, 1'b0);
    chk("claim_bad_rv", r_valid, 4'b1000);

    for (int i = 0; i < 4; i++) begin
      bus.op[2*i +: 2] = 2'b01;
      bus.addr[32*i +: 32] = 32'd40 + 32'(i);
      bus.wdata[32*i +: 32] = 32'h100 + 32'(i);
    end
    bus.req = 4'hF;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (bus.gnt != 0) begin
        gseq[n] = bus.gnt;
        n++;
      end
    end
    bus.req = '0;
    repeat (4) @(negedge clk);
    chk("rr_count", n, 5);
    chk("rr_g0", gseq[0], 4'b0001);
    chk("rr_g1", gseq[1], 4'b0010);
    chk("rr_g2", gseq[2], 4'b0100);
    chk("rr_g3", gseq[3], 4'b1000);
    chk("rr_g4", gseq[4], 4'b0001);
    chk("rr_ram", ram[42], 32'h102);

    run(0, 2'b00, 32'd5, 32'd0);
    chk("rd_lat", lat, 3);
    chk("rd_ok", r_ok, 1'b1);
    chk("rd_data", r_data, 32'd7);

    run(2, 2'b01, 32'd10, 32'h1234);
    chk("wr_lat", lat, 2);
    chk("wr_ok", r_ok, 1'b1);
    chk("wr_data", r_data, 32'd0);
    chk("wr_addr", we_addr, 32'd10);
    chk("wr_din", we_din, 32'h1234);

    run(1, 2'b00, 32'd10, 32'd0);
    chk("rdback_data", r_data, 32'h1234);

    run(0, 2'b00, 32'd100, 32'd0);
    chk("oob_lat", lat, 2);
    chk("oob_ok", r_ok, 1'b0);
    chk("oob_data", r_data, EMPTY);
    chk("oob_en", {saw_re, saw_we}, 2'b00);

    run(3, 2'b11, 32'd3, 32'd1);
    chk("rsv_lat", lat, 2);
    chk("rsv_ok", r_ok, 1'b0);
    chk("rsv_data", r_data, EMPTY);
    chk("rsv_en", {saw_re, saw_we}, 2'b00);

    run(1, 2'b10, 32'd200, 32'd1);
    chk("claim_oob_ok", r_ok, 1'b0);
    chk("claim_oob_lat", lat, 2);

`ifdef GRID_ARB_STATS_EN
    chk("stat_claims", stat_claims, 32'd3);
    chk("stat_fail", stat_claim_fail, 32'd2);
`endif

    chk("mon_re_we", both_cnt, 0);
    chk("mon_rsp_ovl", ovl_cnt, 0);
    chk("mon_gnt_multi", gmul_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
